// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, ALU flag positions, branch condition
// decode and the saturating step used by every counter in the branch unit.
package cpu_pkg;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    COND_NONE,
    COND_EQ,
    COND_LT,
    COND_GT,
    COND_NE
  } branch_cond_t;

  function automatic branch_cond_t decode_cond(input logic [4:0] opcode);
    branch_cond_t c;
    case (opcode)
      BEQ:     c = COND_EQ;
      BLT:     c = COND_LT;
      BGT:     c = COND_GT;
      BNE:     c = COND_NE;
      default: c = COND_NONE;
    endcase
    return c;
  endfunction

  function automatic logic cond_taken(input branch_cond_t c, input logic [1:0] flags);
    logic t;
    case (c)
      COND_EQ: t = flags[FLAG_Z];
      COND_LT: t = flags[FLAG_N];
      COND_GT: t = ~flags[FLAG_Z] & ~flags[FLAG_N];
      COND_NE: t = ~flags[FLAG_Z];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // One saturating step on a value of up to 32 bits; callers cast to their width.
  function automatic logic [31:0] sat_next(input logic [31:0] val, input logic [31:0] max,
                                           input logic inc, input logic dec);
    logic [31:0] r;
    r = val;
    if (inc && !dec && val != max) r = val + 32'd1;
    else if (dec && !inc && val != 32'd0) r = val - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up/down counter (width up to 32 bits) used for the branch statistics.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [31:0] MAX = 32'((64'd1 << W) - 64'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= W'(sat_next(32'(count), MAX, inc, dec));
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with a per-PC saturating-counter predictor,
// registered redirect to the PC mux, wrong-path squash and statistics.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int BHT_IDX_W = 4,
  parameter int CTR_W     = 2,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lu_pc,
  output logic              lu_taken,
  input  logic              rs_valid,
  input  logic              rs_stall,
  input  logic [4:0]        rs_opcode,
  input  logic [1:0]        rs_flags,
  input  logic [PC_W-1:0]   rs_pc,
  input  logic              rs_pred,
  input  logic [PC_W-1:0]   rs_target,
  input  logic [PC_W-1:0]   rs_fallthru,
  output logic              pc_branch_sel_out,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt,
  output logic              squash
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [31:0] CTR_MAX = 32'((1 << CTR_W) - 1);

  logic [CTR_W-1:0] bht [BHT_DEPTH];

  branch_cond_t         cond;
  logic                 eff;
  logic                 resolve;
  logic                 taken;
  logic                 mis;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic [BHT_IDX_W-1:0] rd_idx;

  assign rd_idx   = lu_pc[BHT_IDX_W-1:0];
  assign wr_idx   = rs_pc[BHT_IDX_W-1:0];
  assign lu_taken = bht[rd_idx][CTR_W-1];

  assign cond    = decode_cond(rs_opcode);
  assign eff     = rs_valid & ~rs_stall & ~squash;
  assign resolve = eff & (cond != COND_NONE);
  assign taken   = cond_taken(cond, rs_flags);
  assign mis     = resolve & (taken != rs_pred);

  // squash tracks the registered mispredict; since it blocks eff, it self-clears
  // on the next unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_branch_sel_out <= 1'b0;
      mispredict        <= 1'b0;
      redirect_pc       <= '0;
      squash            <= 1'b0;
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (!rs_stall) begin
      pc_branch_sel_out <= resolve & taken;
      mispredict        <= mis;
      squash            <= mis;
      if (mis) redirect_pc <= taken ? rs_target : rs_fallthru;
      if (resolve) bht[wr_idx] <= CTR_W'(sat_next(32'(bht[wr_idx]), CTR_MAX, taken, ~taken));
    end
  end

  sat_counter #(.W(STAT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (resolve),
    .inc   (1'b1),
    .dec   (1'b0),
    .count (branch_cnt)
  );

  sat_counter #(.W(STAT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (mis),
    .inc   (1'b1),
    .dec   (1'b0),
    .count (mispred_cnt)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lu_pc[PC_W-1:BHT_IDX_W], rs_pc[PC_W-1:BHT_IDX_W]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors checked with
// immediate assertions, covering reset, mispredict/squash, saturation and stall.
module tb_branch_resolve_unit;
  import cpu_pkg::*;

  localparam int PC_W = 16;
  localparam int STAT_W = 16;

  logic              clk;
  logic              rst;
  logic [PC_W-1:0]   lu_pc;
  logic              lu_taken;
  logic              rs_valid;
  logic              rs_stall;
  logic [4:0]        rs_opcode;
  logic [1:0]        rs_flags;
  logic [PC_W-1:0]   rs_pc;
  logic              rs_pred;
  logic [PC_W-1:0]   rs_target;
  logic [PC_W-1:0]   rs_fallthru;
  logic              pc_branch_sel_out;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;
  logic              squash;

  int n_vec = 0;
  int n_err = 0;
  int exp_br = 0;
  int exp_mis = 0;

  branch_resolve_unit #(.PC_W(PC_W), .BHT_IDX_W(4), .CTR_W(2), .STAT_W(STAT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .lu_pc             (lu_pc),
    .lu_taken          (lu_taken),
    .rs_valid          (rs_valid),
    .rs_stall          (rs_stall),
    .rs_opcode         (rs_opcode),
    .rs_flags          (rs_flags),
    .rs_pc             (rs_pc),
    .rs_pred           (rs_pred),
    .rs_target         (rs_target),
    .rs_fallthru       (rs_fallthru),
    .pc_branch_sel_out (pc_branch_sel_out),
    .mispredict        (mispredict),
    .redirect_pc       (redirect_pc),
    .branch_cnt        (branch_cnt),
    .mispred_cnt       (mispred_cnt),
    .squash            (squash)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] op, input logic [1:0] flags,
                       input logic [PC_W-1:0] pc, input logic pred, input logic [PC_W-1:0] tgt);
    rs_valid    = valid;
    rs_opcode   = op;
    rs_flags    = flags;
    rs_pc       = pc;
    rs_pred     = pred;
    rs_target   = tgt;
    rs_fallthru = pc + 16'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [PC_W-1:0] pc, input logic exp);
    lu_pc = pc;
    #1;
    chk(tag, 32'(lu_taken), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic sel, input logic mis,
                         input logic [PC_W-1:0] rdr, input logic sq);
    chk({tag, ".sel"}, 32'(pc_branch_sel_out), 32'(sel));
    chk({tag, ".mis"}, 32'(mispredict), 32'(mis));
    chk({tag, ".redirect"}, 32'(redirect_pc), 32'(rdr));
    chk({tag, ".squash"}, 32'(squash), 32'(sq));
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(exp_br));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mis));
  endtask

  initial begin
    rst = 1'b1;
    rs_stall = 1'b0;
    lu_pc = '0;
    drive(1'b0, 5'b00000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    step();

    // Reset state: every entry weakly not-taken
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) lookup("reset.lu", 16'(i), 1'b0);
    rst = 1'b0;
    step();
    chk_out("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // BEQ taken, predicted not taken -> redirect to target
    drive(1'b1, BEQ, 2'b10, 16'h0003, 1'b0, 16'h0040);
    step();
    exp_br = 1; exp_mis = 1;
    chk_out("beq_mis", 1'b1, 1'b1, 16'h0040, 1'b1);
    lookup("beq.lu13", 16'h0013, 1'b1);

    // Wrong-path BNE right behind the mispredict is squashed
    drive(1'b1, BNE, 2'b00, 16'h0007, 1'b0, 16'h0080);
    step();
    chk_out("squashed", 1'b0, 1'b0, 16'h0040, 1'b0);
    lookup("squashed.lu7", 16'h0007, 1'b0);

    // Same BNE now resolves normally
    step();
    exp_br = 2; exp_mis = 2;
    chk_out("bne_mis", 1'b1, 1'b1, 16'h0080, 1'b1);
    lookup("bne.lu7", 16'h0007, 1'b1);
    drive(1'b0, 5'b00000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_out("post_squash", 1'b0, 1'b0, 16'h0080, 1'b0);

    // Non-branch opcode: no update, redirect holds
    drive(1'b1, 5'b00001, 2'b10, 16'h0003, 1'b0, 16'h0123);
    step();
    chk_out("nonbranch", 1'b0, 1'b0, 16'h0080, 1'b0);

    // Saturation upward at entry 5; lookup of the same index sees the old value
    drive(1'b1, BLT, 2'b01, 16'h0005, 1'b1, 16'h0050);
    lookup("bypass.old", 16'h0005, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_br++;
      chk_out("blt_taken", 1'b1, 1'b0, 16'h0080, 1'b0);
      lookup("blt_taken.lu5", 16'h0005, 1'b1);
    end
    // 11 -> 10 keeps MSB only if the counter did not wrap
    drive(1'b1, BLT, 2'b00, 16'h0005, 1'b0, 16'h0050);
    step();
    exp_br++;
    chk_out("blt_nt", 1'b0, 1'b0, 16'h0080, 1'b0);
    lookup("blt_nt1.lu5", 16'h0005, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_br++;
      lookup("blt_nt.lu5", 16'h0005, 1'b0);
    end
    // 00 + taken -> 01 stays not-taken if the counter did not wrap below zero
    drive(1'b1, BLT, 2'b01, 16'h0005, 1'b1, 16'h0050);
    step();
    exp_br++;
    lookup("blt_floor.lu5", 16'h0005, 1'b0);
    chk_out("blt_floor", 1'b1, 1'b0, 16'h0080, 1'b0);

    // BGT not taken (Z=1) with predict taken -> redirect to fallthrough
    drive(1'b1, BGT, 2'b10, 16'h0009, 1'b1, 16'h0200);
    step();
    exp_br++; exp_mis++;
    chk_out("bgt_mis", 1'b0, 1'b1, 16'h000A, 1'b1);

    // Stall during the pulse: everything holds
    rs_stall = 1'b1;
    drive(1'b1, BEQ, 2'b10, 16'h0009, 1'b0, 16'h0300);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall", 1'b0, 1'b1, 16'h000A, 1'b1);
    end
    rs_stall = 1'b0;
    step();
    chk_out("stall_squash", 1'b0, 1'b0, 16'h000A, 1'b0);

    // BGT taken (Z=0,N=0) correctly predicted
    drive(1'b1, BGT, 2'b00, 16'h0009, 1'b1, 16'h0300);
    step();
    exp_br++;
    chk_out("bgt_taken", 1'b1, 1'b0, 16'h000A, 1'b0);

    // Reset asserted mid-pulse clears everything asynchronously
    drive(1'b1, BEQ, 2'b10, 16'h0003, 1'b0, 16'h0444);
    step();
    exp_br++; exp_mis++;
    chk_out("pre_rst", 1'b1, 1'b1, 16'h0444, 1'b1);
    #3 rst = 1'b1;
    #1;
    exp_br = 0; exp_mis = 0;
    chk_out("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    lookup("async_rst.lu3", 16'h0003, 1'b0);
    lookup("async_rst.lu7", 16'h0007, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 5'b00000, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    chk_out("after_rst", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Statistics saturation at all-ones
    drive(1'b1, BEQ, 2'b10, 16'h0000, 1'b1, 16'h0010);
    for (int i = 0; i < 65534; i++) step();
    chk("stat.fffe", 32'(branch_cnt), 32'h0000FFFE);
    step();
    step();
    chk("stat.ffff", 32'(branch_cnt), 32'h0000FFFF);
    chk("stat.mis", 32'(mispred_cnt), 32'h00000000);
    chk("stat.sel", 32'(pc_branch_sel_out), 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
